vga_layer_renderer: RTL and testbench

//  Pipelined, clocked successor to the single-player/single-obstacle pixel colouriser.

---
 rtl/vga_layer_renderer_pkg.sv | 17 +
 rtl/vga_obj_hit.sv | 25 ++
 rtl/vga_layer_renderer.sv | 174 +++++++++++++++++
 tb/tb_vga_layer_renderer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_layer_renderer_pkg.sv
// Shared colour constants, flash counter width and packed-field helpers for the layer renderer.
package vga_layer_renderer_pkg;

  localparam int unsigned RGB_W   = 24;
  localparam int unsigned FLASH_W = 4;

  localparam logic [RGB_W-1:0] C_BLACK = 24'h00_00_00;
  localparam logic [RGB_W-1:0] C_WHITE = 24'hFF_FF_FF;
  localparam logic [RGB_W-1:0] C_GREEN = 24'h00_FF_00;
  localparam logic [RGB_W-1:0] C_FLASH = 24'hFF_C0_C0;

  // Low bit of field idx in a bus packed as {f[n-1], ..., f[1], f[0]}.
  function automatic int unsigned fld_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/vga_obj_hit.sv
// Combinational rectangle test; right/bottom edges are computed one bit wider so they clip.
module vga_obj_hit #(
  parameter int unsigned COORD_W = 10
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_ox,
  input  logic [COORD_W-1:0] i_oy,
  input  logic [COORD_W-1:0] i_ow,
  input  logic [COORD_W-1:0] i_oh,
  output logic               o_hit
);

  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;

  assign w_x_end = {1'b0, i_ox} + {1'b0, i_ow};
  assign w_y_end = {1'b0, i_oy} + {1'b0, i_oh};

  assign o_hit = i_en && (i_ow != '0) && (i_oh != '0) &&
                 (i_x >= i_ox) && ({1'b0, i_x} < w_x_end) &&
                 (i_y >= i_oy) && ({1'b0, i_y} < w_y_end);

endmodule

// File: rtl/vga_layer_renderer.sv
// Two-stage pixel colouriser: prioritised object layers, bank bar and frame-counted hit flash,
// all drawn from attributes shadowed at frame_start.
module vga_layer_renderer
  import vga_layer_renderer_pkg::*;
#(
  parameter int unsigned NUM_OBJ      = 4,
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned LEVEL_W      = 8,
  parameter int unsigned BOX_Y_BASE   = 345,
  parameter int unsigned BANK_X_START = 50,
  parameter int unsigned BANK_WIDTH   = 60,
  parameter int unsigned BANK_MAX_H   = 240,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [NUM_OBJ-1:0]         obj_en,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_x,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_y,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_w,
  input  logic [NUM_OBJ*COORD_W-1:0] obj_h,
  input  logic [NUM_OBJ*RGB_W-1:0]   obj_rgb,
  input  logic [LEVEL_W-1:0]         bank_level,
  input  logic                       hit_flash,
  input  logic [COORD_W-1:0]         x,
  input  logic [COORD_W-1:0]         y,
  input  logic                       active_pixels,
  input  logic [1:0]                 sync_in,
  output logic [7:0]                 VGA_R,
  output logic [7:0]                 VGA_G,
  output logic [7:0]                 VGA_B,
  output logic                       active_out,
  output logic [1:0]                 sync_out
);

  localparam int unsigned CW1 = COORD_W + 1;

  localparam logic [COORD_W-1:0] L_BANK_X0 = COORD_W'(BANK_X_START);
  localparam logic [CW1-1:0]     L_BANK_X1 = CW1'(BANK_X_START + BANK_WIDTH);
  localparam logic [COORD_W-1:0] L_BASE    = COORD_W'(BOX_Y_BASE);
  localparam logic [COORD_W-1:0] L_MAX_H   = COORD_W'(BANK_MAX_H);

  // Shadow copies of the per-frame attributes.
  logic [NUM_OBJ-1:0]         r_en;
  logic [NUM_OBJ*COORD_W-1:0] r_ox;
  logic [NUM_OBJ*COORD_W-1:0] r_oy;
  logic [NUM_OBJ*COORD_W-1:0] r_ow;
  logic [NUM_OBJ*COORD_W-1:0] r_oh;
  logic [NUM_OBJ*RGB_W-1:0]   r_rgb;
  logic [LEVEL_W-1:0]         r_bank_level;

  logic [FLASH_W-1:0] r_flash_cnt;
  logic [FLASH_W-1:0] w_flash_cnt_d;

  logic [NUM_OBJ-1:0] w_hit;
  logic [NUM_OBJ-1:0] r_s1_hit;
  logic               r_s1_bank;
  logic               r_s1_act;
  logic [1:0]         r_s1_sync;

  logic [COORD_W-1:0] w_bank_h;
  logic               w_bank_hit;
  logic [RGB_W-1:0]   w_rgb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en         <= '0;
      r_ox         <= '0;
      r_oy         <= '0;
      r_ow         <= '0;
      r_oh         <= '0;
      r_rgb        <= '0;
      r_bank_level <= '0;
    end else if (frame_start) begin
      r_en         <= obj_en;
      r_ox         <= obj_x;
      r_oy         <= obj_y;
      r_ow         <= obj_w;
      r_oh         <= obj_h;
      r_rgb        <= obj_rgb;
      r_bank_level <= bank_level;
    end
  end

  // A load on the same cycle as frame_start takes precedence over the decrement.
  always_comb begin
    w_flash_cnt_d = r_flash_cnt;
    if (hit_flash) begin
      w_flash_cnt_d = FLASH_W'(FLASH_FRAMES);
    end else if (frame_start && (r_flash_cnt != '0)) begin
      w_flash_cnt_d = r_flash_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flash_cnt <= '0;
    end else begin
      r_flash_cnt <= w_flash_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    vga_obj_hit #(
      .COORD_W (COORD_W)
    ) u_obj_hit (
      .i_en  (r_en[g]),
      .i_x   (x),
      .i_y   (y),
      .i_ox  (r_ox[fld_lo(g, COORD_W) +: COORD_W]),
      .i_oy  (r_oy[fld_lo(g, COORD_W) +: COORD_W]),
      .i_ow  (r_ow[fld_lo(g, COORD_W) +: COORD_W]),
      .i_oh  (r_oh[fld_lo(g, COORD_W) +: COORD_W]),
      .o_hit (w_hit[g])
    );
  end

  assign w_bank_h = (32'(r_bank_level) > BANK_MAX_H) ? L_MAX_H : COORD_W'(r_bank_level);

  // BASE-h < y is rewritten as y+h > BASE so a tall bar cannot underflow.
  assign w_bank_hit = (x >= L_BANK_X0) && ({1'b0, x} < L_BANK_X1) && (y <= L_BASE) &&
                      (({1'b0, y} + {1'b0, w_bank_h}) > {1'b0, L_BASE});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_hit  <= '0;
      r_s1_bank <= 1'b0;
      r_s1_act  <= 1'b0;
      r_s1_sync <= '0;
    end else begin
      r_s1_hit  <= w_hit;
      r_s1_bank <= w_bank_hit;
      r_s1_act  <= active_pixels;
      r_s1_sync <= sync_in;
    end
  end

  // Later assignments override earlier ones, so the lowest-priority layer is written first.
  always_comb begin
    w_rgb = C_WHITE;
    if ((r_flash_cnt != '0) && r_flash_cnt[0]) begin
      w_rgb = C_FLASH;
    end
    if (r_s1_bank) begin
      w_rgb = C_GREEN;
    end
    for (int i = int'(NUM_OBJ) - 1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_rgb = r_rgb[fld_lo(i, RGB_W) +: RGB_W];
      end
    end
    if (!r_s1_act) begin
      w_rgb = C_BLACK;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      active_out <= 1'b0;
      sync_out   <= '0;
    end else begin
      VGA_R      <= w_rgb[23:16];
      VGA_G      <= w_rgb[15:8];
      VGA_B      <= w_rgb[7:0];
      active_out <= r_s1_act;
      sync_out   <= r_s1_sync;
    end
  end

endmodule

// File: tb/tb_vga_layer_renderer.sv
// Directed table-driven bench for vga_layer_renderer plus hand sequences for latency,
// tearing, flash counting and asynchronous reset.
module tb_vga_layer_renderer;

  localparam int N  = 4;
  localparam int CW = 10;

  localparam logic [23:0] BLK = 24'h000000;
  localparam logic [23:0] WHT = 24'hFFFFFF;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] FLS = 24'hFFC0C0;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] BLU = 24'h0000FF;
  localparam logic [23:0] OTH = 24'h123456;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            frame_start = 1'b0;
  logic [N-1:0]    obj_en = '0;
  logic [N*CW-1:0] obj_x = '0;
  logic [N*CW-1:0] obj_y = '0;
  logic [N*CW-1:0] obj_w = '0;
  logic [N*CW-1:0] obj_h = '0;
  logic [N*24-1:0] obj_rgb = '0;
  logic [7:0]      bank_level = '0;
  logic            hit_flash = 1'b0;
  logic [CW-1:0]   x = '0;
  logic [CW-1:0]   y = '0;
  logic            active_pixels = 1'b0;
  logic [1:0]      sync_in = '0;
  logic [7:0]      VGA_R, VGA_G, VGA_B;
  logic            active_out;
  logic [1:0]      sync_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          grp;
    logic [9:0]  px;
    logic [9:0]  py;
    logic        act;
    logic [1:0]  sync;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];

  vga_layer_renderer dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .obj_en        (obj_en),
    .obj_x         (obj_x),
    .obj_y         (obj_y),
    .obj_w         (obj_w),
    .obj_h         (obj_h),
    .obj_rgb       (obj_rgb),
    .bank_level    (bank_level),
    .hit_flash     (hit_flash),
    .x             (x),
    .y             (y),
    .active_pixels (active_pixels),
    .sync_in       (sync_in),
    .VGA_R         (VGA_R),
    .VGA_G         (VGA_G),
    .VGA_B         (VGA_B),
    .active_out    (active_out),
    .sync_out      (sync_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int g, input int px, input int py, input logic act,
                     input logic [1:0] sync, input logic [23:0] exp);
    vec_t v;
    v.grp  = g;
    v.px   = 10'(px);
    v.py   = 10'(py);
    v.act  = act;
    v.sync = sync;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic set_obj(input int i, input logic en, input int ox, input int oy,
                         input int ow, input int oh, input logic [23:0] rgb);
    obj_en[i]             = en;
    obj_x[i*CW +: CW]     = 10'(ox);
    obj_y[i*CW +: CW]     = 10'(oy);
    obj_w[i*CW +: CW]     = 10'(ow);
    obj_h[i*CW +: CW]     = 10'(oh);
    obj_rgb[i*24 +: 24]   = rgb;
  endtask

  task automatic frame_pulse(input logic flash);
    @(negedge clk);
    frame_start = 1'b1;
    hit_flash   = flash;
    @(negedge clk);
    frame_start = 1'b0;
    hit_flash   = 1'b0;
  endtask

  // Drive a pixel, wait exactly two rising edges, sample just after the second.
  task automatic pix(input int px, input int py, input logic act, input logic [1:0] sync);
    @(negedge clk);
    x             = 10'(px);
    y             = 10'(py);
    active_pixels = act;
    sync_in       = sync;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_grp(input int g);
    foreach (vecs[i]) begin
      if (vecs[i].grp == g) begin
        pix(vecs[i].px, vecs[i].py, vecs[i].act, vecs[i].sync);
        chk($sformatf("g%0d v%0d rgb (%0d,%0d)", g, i, vecs[i].px, vecs[i].py),
            {VGA_R, VGA_G, VGA_B}, vecs[i].exp);
        chk($sformatf("g%0d v%0d active", g, i), {23'd0, active_out}, {23'd0, vecs[i].act});
        chk($sformatf("g%0d v%0d sync", g, i), {22'd0, sync_out}, {22'd0, vecs[i].sync});
      end
    end
  endtask

  initial begin
    // 1: single red object
    add(1, 105, 110, 1'b1, 2'b00, RED);
    add(1, 120, 110, 1'b1, 2'b01, WHT);
    add(1, 100, 100, 1'b1, 2'b10, RED);
    add(1, 119, 119, 1'b1, 2'b00, RED);
    add(1,  99, 105, 1'b1, 2'b00, WHT);
    add(1, 110, 120, 1'b1, 2'b00, WHT);
    add(1, 105, 110, 1'b0, 2'b11, BLK);
    // 2: overlap, obj0 wins
    add(2,  55,  55, 1'b1, 2'b00, RED);
    add(2,  69,  69, 1'b1, 2'b00, RED);
    add(2,  41,  60, 1'b1, 2'b00, BLU);
    add(2,  70,  60, 1'b1, 2'b00, WHT);
    // 3: obj0 disabled
    add(3,  55,  55, 1'b1, 2'b00, BLU);
    // 4: bank_level 30
    add(4,  50, 316, 1'b1, 2'b00, GRN);
    add(4, 109, 345, 1'b1, 2'b00, GRN);
    add(4,  80, 330, 1'b1, 2'b00, GRN);
    add(4,  50, 315, 1'b1, 2'b00, WHT);
    add(4, 110, 330, 1'b1, 2'b00, WHT);
    add(4,  49, 330, 1'b1, 2'b00, WHT);
    add(4,  80, 346, 1'b1, 2'b00, WHT);
    // 5: bank_level 255 clamps to 240
    add(5,  50, 106, 1'b1, 2'b00, GRN);
    add(5,  50, 105, 1'b1, 2'b00, WHT);
    add(5,  60, 345, 1'b1, 2'b00, GRN);
    // 6: clipping at the right edge
    add(6, 1023,  5, 1'b1, 2'b00, OTH);
    add(6, 1020,  5, 1'b1, 2'b00, OTH);
    add(6,    0,  5, 1'b1, 2'b00, WHT);
    add(6,    3,  5, 1'b1, 2'b00, WHT);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset rgb", {VGA_R, VGA_G, VGA_B}, BLK);
    chk("reset active", {23'd0, active_out}, 24'd0);
    chk("reset sync", {22'd0, sync_out}, 24'd0);
    @(negedge clk);
    rst = 1'b1;

    @(negedge clk);
    set_obj(0, 1'b1, 100, 100, 20, 20, RED);
    frame_pulse(1'b0);
    run_grp(1);

    // Latency: new pixel visible on the second edge, not the first
    pix(120, 110, 1'b1, 2'b00);
    @(negedge clk);
    x = 10'd105;
    y = 10'd110;
    @(posedge clk);
    #1;
    chk("latency 1clk", {VGA_R, VGA_G, VGA_B}, WHT);
    @(posedge clk);
    #1;
    chk("latency 2clk", {VGA_R, VGA_G, VGA_B}, RED);

    // Tearing: moving obj0 has no effect until frame_start
    @(negedge clk);
    set_obj(0, 1'b1, 300, 100, 20, 20, RED);
    pix(105, 110, 1'b1, 2'b00);
    chk("tear old pos", {VGA_R, VGA_G, VGA_B}, RED);
    pix(305, 110, 1'b1, 2'b00);
    chk("tear new pos early", {VGA_R, VGA_G, VGA_B}, WHT);
    frame_pulse(1'b0);
    pix(105, 110, 1'b1, 2'b00);
    chk("tear old pos after fs", {VGA_R, VGA_G, VGA_B}, WHT);
    pix(305, 110, 1'b1, 2'b00);
    chk("tear new pos after fs", {VGA_R, VGA_G, VGA_B}, RED);

    @(negedge clk);
    set_obj(0, 1'b1, 50, 50, 20, 20, RED);
    set_obj(1, 1'b1, 40, 40, 30, 30, BLU);
    frame_pulse(1'b0);
    run_grp(2);
    @(negedge clk);
    obj_en[0] = 1'b0;
    frame_pulse(1'b0);
    run_grp(3);

    @(negedge clk);
    obj_en = '0;
    bank_level = 8'd30;
    frame_pulse(1'b0);
    run_grp(4);
    @(negedge clk);
    bank_level = 8'd255;
    frame_pulse(1'b0);
    run_grp(5);

    @(negedge clk);
    bank_level = 8'd0;
    set_obj(0, 1'b1, 1020, 0, 20, 20, OTH);
    frame_pulse(1'b0);
    run_grp(6);

    // Flash: load with frame_start leaves count at 8, then counts down to 0
    @(negedge clk);
    obj_en = '0;
    frame_pulse(1'b1);
    pix(500, 400, 1'b1, 2'b00);
    chk("flash cnt8", {VGA_R, VGA_G, VGA_B}, WHT);
    for (int k = 1; k <= 9; k++) begin
      int cnt;
      cnt = (k > 8) ? 0 : 8 - k;
      frame_pulse(1'b0);
      pix(500, 400, 1'b1, 2'b00);
      chk($sformatf("flash after %0d fs", k), {VGA_R, VGA_G, VGA_B},
          (cnt % 2 == 1) ? FLS : WHT);
    end
    // Restart mid-flash
    frame_pulse(1'b1);
    frame_pulse(1'b0);
    frame_pulse(1'b0);
    frame_pulse(1'b1);
    frame_pulse(1'b0);
    pix(500, 400, 1'b1, 2'b00);
    chk("flash restart", {VGA_R, VGA_G, VGA_B}, FLS);
    @(negedge clk);
    hit_flash = 1'b1;
    @(negedge clk);
    hit_flash = 1'b0;
    pix(500, 400, 1'b1, 2'b00);
    chk("flash reload no fs", {VGA_R, VGA_G, VGA_B}, WHT);

    // Asynchronous reset mid-line
    @(negedge clk);
    set_obj(0, 1'b1, 100, 100, 20, 20, RED);
    frame_pulse(1'b0);
    pix(105, 110, 1'b1, 2'b10);
    chk("pre-reset rgb", {VGA_R, VGA_G, VGA_B}, RED);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async reset rgb", {VGA_R, VGA_G, VGA_B}, BLK);
    chk("async reset sync", {22'd0, sync_out}, 24'd0);
    chk("async reset active", {23'd0, active_out}, 24'd0);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset obj hidden", {VGA_R, VGA_G, VGA_B}, WHT);
    frame_pulse(1'b0);
    pix(105, 110, 1'b1, 2'b00);
    chk("post-reset obj back", {VGA_R, VGA_G, VGA_B}, RED);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
